// File: rtl/irrigation_actuator_sequencer.sv
// Registered actuator sequencer: dwell timing, sprinkler/dripper exclusion, latched alarm.
// Optional on-time watchdog enabled by defining IRRIGATION_WATCHDOG_EN.
module irrigation_actuator_sequencer #(
  parameter int COUNT_WIDTH   = 8,
  parameter int MIN_ON_TICKS  = 8,
  parameter int MIN_OFF_TICKS = 4,
  parameter int MAX_ON_TICKS  = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       supply_request,
  input  logic       alarm_request,
  input  logic       sprinkler_request,
  input  logic       dripper_request,
  input  logic       alarm_ack,
  output logic       supply_valve,
  output logic       sprinkler_pump,
  output logic       dripper_valve,
  output logic       alarm_latched,
  output logic       timeout,
  output logic [1:0] state
);

  // state    | meaning
  // IDLE     | all irrigators off, waiting for a request with no alarm
  // SPRINKLE | sprinkler pump on, counting on-ticks
  // DRIP     | dripper valve on, counting on-ticks
  // HOLD_OFF | all irrigators off, counting off-ticks before re-arming
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPRINKLE = 2'd1,
    DRIP     = 2'd2,
    HOLD_OFF = 2'd3
  } state_t;

`ifdef IRRIGATION_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam logic [COUNT_WIDTH-1:0] MIN_ON_C  = COUNT_WIDTH'(MIN_ON_TICKS);
  localparam logic [COUNT_WIDTH-1:0] MIN_OFF_C = COUNT_WIDTH'(MIN_OFF_TICKS);
  localparam logic [COUNT_WIDTH-1:0] MAX_ON_C  = COUNT_WIDTH'(MAX_ON_TICKS);
  localparam logic [COUNT_WIDTH-1:0] CNT_SAT   = '1;

  state_t                 state_q;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] counter;
  logic                   alarm_next;
  logic                   wd_fire;
  logic                   on_done;
  logic                   off_done;
  logic                   wd_hit;

  assign on_done  = (counter >= MIN_ON_C);
  assign off_done = (counter >= MIN_OFF_C);
  assign wd_hit   = WD_EN && (counter >= MAX_ON_C);

  // Set has priority over acknowledge.
  assign alarm_next = alarm_request | (alarm_latched & ~alarm_ack);

  always_comb begin
    state_next = state_q;
    wd_fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!alarm_next) begin
          if (sprinkler_request)    state_next = SPRINKLE;
          else if (dripper_request) state_next = DRIP;
        end
      end
      SPRINKLE: begin
        if (alarm_next) state_next = HOLD_OFF;
        else if (wd_hit) begin
          state_next = HOLD_OFF;
          wd_fire    = 1'b1;
        end else if (!sprinkler_request && on_done) state_next = HOLD_OFF;
      end
      DRIP: begin
        if (alarm_next) state_next = HOLD_OFF;
        else if (wd_hit) begin
          state_next = HOLD_OFF;
          wd_fire    = 1'b1;
        end else if (!dripper_request && on_done) state_next = HOLD_OFF;
      end
      HOLD_OFF: begin
        if (off_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      counter        <= '0;
      supply_valve   <= 1'b0;
      sprinkler_pump <= 1'b0;
      dripper_valve  <= 1'b0;
      alarm_latched  <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      state_q        <= state_next;
      supply_valve   <= supply_request & ~alarm_next;
      sprinkler_pump <= (state_next == SPRINKLE);
      dripper_valve  <= (state_next == DRIP);
      alarm_latched  <= alarm_next;
      timeout        <= wd_fire;
      // Counter restarts on every state entry and saturates instead of wrapping.
      if (state_next != state_q)
        counter <= '0;
      else if (state_q != IDLE && tick && counter != CNT_SAT)
        counter <= counter + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_irrigation_actuator_sequencer.sv
// Directed self-checking bench for irrigation_actuator_sequencer (MIN_ON=8, MIN_OFF=4, MAX_ON=16).
module tb_irrigation_actuator_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       supply_request;
  logic       alarm_request;
  logic       sprinkler_request;
  logic       dripper_request;
  logic       alarm_ack;
  logic       supply_valve;
  logic       sprinkler_pump;
  logic       dripper_valve;
  logic       alarm_latched;
  logic       timeout;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_SPR = 2'd1, S_DRIP = 2'd2, S_HOLD = 2'd3;

  irrigation_actuator_sequencer #(
    .COUNT_WIDTH(8), .MIN_ON_TICKS(8), .MIN_OFF_TICKS(4), .MAX_ON_TICKS(16)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .supply_request(supply_request), .alarm_request(alarm_request),
    .sprinkler_request(sprinkler_request), .dripper_request(dripper_request),
    .alarm_ack(alarm_ack), .supply_valve(supply_valve),
    .sprinkler_pump(sprinkler_pump), .dripper_valve(dripper_valve),
    .alarm_latched(alarm_latched), .timeout(timeout), .state(state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (state !== S_IDLE && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (state !== S_IDLE) begin
      errors++;
      $display("FAIL %s: state=%0d required %0d within %0d cycles", name, state, S_IDLE, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({supply_valve, sprinkler_pump, dripper_valve, alarm_latched, timeout, state} !== 7'b0) begin
      errors++;
      $display("FAIL reset_values: outs=%b state=%0d required all 0", 
               {supply_valve, sprinkler_pump, dripper_valve, alarm_latched, timeout}, state);
    end
    reset = 1'b0;
  endtask

  task automatic test_min_dwell();
    logic [1:0] exp_state;
    logic       exp_pump;
    sprinkler_request = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 2) sprinkler_request = 1'b0;
      exp_state = (i <= 9) ? S_SPR : (i <= 14) ? S_HOLD : S_IDLE;
      exp_pump  = (i <= 9);
      checks++;
      if (state !== exp_state || sprinkler_pump !== exp_pump || dripper_valve !== 1'b0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL dwell_cycle%0d: state=%0d pump=%b drip=%b to=%b required state=%0d pump=%b drip=0 to=0",
                 i, state, sprinkler_pump, dripper_valve, timeout, exp_state, exp_pump);
      end
    end
  endtask

  task automatic test_priority();
    int bad = 0;
    sprinkler_request = 1'b1;
    dripper_request   = 1'b1;
    step();
    checks++;
    if (sprinkler_pump !== 1'b1 || dripper_valve !== 1'b0 || state !== S_SPR) begin
      errors++;
      $display("FAIL priority_first: pump=%b drip=%b state=%0d required pump=1 drip=0 state=1",
               sprinkler_pump, dripper_valve, state);
    end
    step();
    step();
    sprinkler_request = 1'b0;
    dripper_request   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dripper_valve !== 1'b0 || (sprinkler_pump & dripper_valve) !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL priority_exclusion: dripper on in %0d cycles required 0", bad);
    end
    wait_idle("priority_idle", 20);
  endtask

  task automatic test_alarm_and_ack();
    supply_request  = 1'b1;
    dripper_request = 1'b1;
    step();
    step();
    step();
    checks++;
    if (dripper_valve !== 1'b1 || supply_valve !== 1'b1 || state !== S_DRIP) begin
      errors++;
      $display("FAIL alarm_pre: drip=%b supply=%b state=%0d required 1 1 2", dripper_valve, supply_valve, state);
    end
    alarm_request = 1'b1;
    step();
    alarm_request = 1'b0;
    checks++;
    if (dripper_valve !== 1'b0 || supply_valve !== 1'b0 || alarm_latched !== 1'b1 || state !== S_HOLD) begin
      errors++;
      $display("FAIL alarm_off: drip=%b supply=%b alarm=%b state=%0d required 0 0 1 3",
               dripper_valve, supply_valve, alarm_latched, state);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (state !== S_HOLD || alarm_latched !== 1'b1 || supply_valve !== 1'b0) begin
        errors++;
        $display("FAIL alarm_hold%0d: state=%0d alarm=%b supply=%b required 3 1 0",
                 i, state, alarm_latched, supply_valve);
      end
    end
    step();
    step();
    step();
    checks++;
    if (state !== S_IDLE || dripper_valve !== 1'b0 || alarm_latched !== 1'b1) begin
      errors++;
      $display("FAIL alarm_blocks_start: state=%0d drip=%b alarm=%b required 0 0 1",
               state, dripper_valve, alarm_latched);
    end
    alarm_ack     = 1'b1;
    alarm_request = 1'b1;
    step();
    checks++;
    if (alarm_latched !== 1'b1 || state !== S_IDLE) begin
      errors++;
      $display("FAIL set_wins_over_ack: alarm=%b state=%0d required 1 0", alarm_latched, state);
    end
    alarm_request = 1'b0;
    step();
    alarm_ack = 1'b0;
    checks++;
    if (alarm_latched !== 1'b0 || supply_valve !== 1'b1 || dripper_valve !== 1'b1 || state !== S_DRIP) begin
      errors++;
      $display("FAIL ack_clears: alarm=%b supply=%b drip=%b state=%0d required 0 1 1 2",
               alarm_latched, supply_valve, dripper_valve, state);
    end
    supply_request  = 1'b0;
    dripper_request = 1'b0;
    wait_idle("alarm_idle", 30);
  endtask

  task automatic test_reset_mid_run();
    sprinkler_request = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (state !== S_SPR || dut.counter !== 8'd3) begin
      errors++;
      $display("FAIL mid_pre: state=%0d counter=%0d required 1 3", state, dut.counter);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({supply_valve, sprinkler_pump, dripper_valve, alarm_latched, timeout, state} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset: outs=%b state=%0d required all 0",
               {supply_valve, sprinkler_pump, dripper_valve, alarm_latched, timeout}, state);
    end
    step();
    checks++;
    if (sprinkler_pump !== 1'b1 || state !== S_SPR) begin
      errors++;
      $display("FAIL mid_restart: pump=%b state=%0d required 1 1", sprinkler_pump, state);
    end
    sprinkler_request = 1'b0;
    wait_idle("mid_idle", 30);
  endtask

  task automatic test_tick_gating();
    tick = 1'b0;
    sprinkler_request = 1'b1;
    step();
    sprinkler_request = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (state !== S_SPR || sprinkler_pump !== 1'b1) begin
      errors++;
      $display("FAIL tick_hold: state=%0d pump=%b required 1 1", state, sprinkler_pump);
    end
    tick = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (state !== S_SPR) begin
      errors++;
      $display("FAIL tick_count8: state=%0d required 1", state);
    end
    step();
    checks++;
    if (state !== S_HOLD || sprinkler_pump !== 1'b0) begin
      errors++;
      $display("FAIL tick_exit: state=%0d pump=%b required 3 0", state, sprinkler_pump);
    end
    wait_idle("tick_idle", 20);
  endtask

`ifdef IRRIGATION_WATCHDOG_EN
  task automatic test_watchdog();
    int pulses = 0;
    dripper_request = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (timeout === 1'b1) pulses++;
      if (i == 17 || i == 18 || i == 23 || i == 24) begin
        checks++;
        if (dripper_valve !== (i == 17 || i == 24)) begin
          errors++;
          $display("FAIL wd_drip_cycle%0d: drip=%b required %b", i, dripper_valve, (i == 17 || i == 24));
        end
      end
      if (i == 18) begin
        checks++;
        if (timeout !== 1'b1 || state !== S_HOLD) begin
          errors++;
          $display("FAIL wd_pulse: timeout=%b state=%0d required 1 3", timeout, state);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL wd_pulse_count: %0d required 1", pulses);
    end
    dripper_request = 1'b0;
    wait_idle("wd_idle", 40);
  endtask
`else
  task automatic test_no_watchdog();
    int pulses = 0;
    dripper_request = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (timeout !== 1'b0) pulses++;
    end
    checks++;
    if (dripper_valve !== 1'b1 || state !== S_DRIP || pulses != 0) begin
      errors++;
      $display("FAIL no_wd_run: drip=%b state=%0d timeouts=%0d required 1 2 0", dripper_valve, state, pulses);
    end
    dripper_request = 1'b0;
    wait_idle("no_wd_idle", 30);
  endtask
`endif

  initial begin
    reset = 1'b1; tick = 1'b1;
    supply_request = 1'b0; alarm_request = 1'b0;
    sprinkler_request = 1'b0; dripper_request = 1'b0; alarm_ack = 1'b0;
    test_reset();
    test_min_dwell();
    test_priority();
    test_alarm_and_ack();
    test_reset_mid_run();
    test_tick_gating();
`ifdef IRRIGATION_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
